// File: rtl/misr_signature_analyzer_pkg.sv
// Shared BIST definitions: default MISR width, feedback taps and analyzer FSM states.
package bist_pkg;
    localparam int BIST_WIDTH = 5;
    localparam logic [BIST_WIDTH-1:0] DEFAULT_TAPS = 5'b10100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        DONE    = 2'd2
    } state_t;
endpackage

// File: rtl/misr_signature_analyzer_core.sv
// MISR register with tap-mask feedback; compacts din in one cycle when shift_en is high.
// The optional scan port (MISR_SCAN_OUT_EN) shifts the register right, filling the MSB with zero.
import bist_pkg::*;

module misr_core #(
    parameter int                 WIDTH = BIST_WIDTH,
    parameter logic [WIDTH-1:0]   TAPS  = DEFAULT_TAPS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             shift_en,
`ifdef MISR_SCAN_OUT_EN
    input  logic             scan,
`endif
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = {sig[WIDTH-2:0], ^(sig & TAPS)} ^ din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig <= seed;
        end else if (load) begin
            sig <= seed;
        end else if (shift_en) begin
            sig <= nxt;
`ifdef MISR_SCAN_OUT_EN
        end else if (scan) begin
            sig <= {1'b0, sig[WIDTH-1:1]};
`endif
        end
    end

endmodule

// File: rtl/misr_signature_analyzer.sv
// Compacts NUM_CYCLES enabled response vectors into a MISR and compares the result with golden.
// Done follows NUM_CYCLES enb-high cycles after start; enb low stalls. Scan-out: MISR_SCAN_OUT_EN.
import bist_pkg::*;

module misr_signature_analyzer #(
    parameter int               WIDTH      = BIST_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = DEFAULT_TAPS,
    parameter logic [WIDTH-1:0] SEED       = '0,
    parameter int               NUM_CYCLES = 31,
    parameter int               CNT_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] golden,
`ifdef MISR_SCAN_OUT_EN
    input  logic             scan_shift,
    output logic             scan_out,
`endif
    output logic [WIDTH-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] nxt;
    logic             load;
    logic             shift_en;

    // start reseeds from IDLE or DONE; it is ignored mid-run
    assign load     = start && (state != COMPACT);
    assign shift_en = (state == COMPACT) && enb;

`ifdef MISR_SCAN_OUT_EN
    logic scan;
    assign scan     = (state == DONE) && scan_shift;
    assign scan_out = signature[0];
`endif

    misr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .seed     (SEED),
        .shift_en (shift_en),
`ifdef MISR_SCAN_OUT_EN
        .scan     (scan),
`endif
        .din      (din),
        .sig      (signature),
        .nxt      (nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COMPACT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                COMPACT: begin
                    if (enb) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (nxt == golden);
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= COMPACT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_misr_signature_analyzer.sv
// Directed bench: a 3-cycle and a 2-cycle analyzer share stimulus; expected signatures are hand-computed.
`timescale 1ns/1ps
module tb_misr_signature_analyzer;

    logic       clk = 1'b0;
    logic       reset, enb, start;
    logic [4:0] din, golden;
    logic [4:0] sig3, sig2;
    logic       busy3, done3, pass3, busy2, done2, pass2;
`ifdef MISR_SCAN_OUT_EN
    logic       scan_shift;
    logic       scan_out3, scan_out2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    misr_signature_analyzer #(.NUM_CYCLES(3), .CNT_W(2)) dut3 (
        .clk(clk), .reset(reset), .enb(enb), .start(start), .din(din), .golden(golden),
`ifdef MISR_SCAN_OUT_EN
        .scan_shift(scan_shift), .scan_out(scan_out3),
`endif
        .signature(sig3), .busy(busy3), .done(done3), .pass(pass3));

    misr_signature_analyzer #(.NUM_CYCLES(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .enb(enb), .start(start), .din(din), .golden(golden),
`ifdef MISR_SCAN_OUT_EN
        .scan_shift(scan_shift), .scan_out(scan_out2),
`endif
        .signature(sig2), .busy(busy2), .done(done2), .pass(pass2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // one rising edge, then settle before sampling or driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run of test 1 on dut3: din 00001,00000,00000 -> 00001,00010,00100, golden 00100.
    // hold_start keeps start high through the run to show it is ignored while compacting.
    task automatic run_t1(input string tag, input logic hold_start);
        golden = 5'b00100;
        start  = 1'b1;
        step();
        chk({tag, "_start_busy"}, busy3, 1);
        chk({tag, "_start_sig"},  sig3, 5'b00000);
        start = hold_start;
        enb   = 1'b1;
        din   = 5'b00001;
        step();
        chk({tag, "_c1"}, sig3, 5'b00001);
        din = 5'b00000;
        step();
        chk({tag, "_c2"}, sig3, 5'b00010);
        chk({tag, "_c2_done"}, done3, 0);
        step();
        chk({tag, "_c3"}, sig3, 5'b00100);
        chk({tag, "_done"}, {busy3, done3, pass3}, 3'b011);
        start = 1'b0;
        enb   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enb = 1'b0; start = 1'b0; din = '0; golden = '0;
`ifdef MISR_SCAN_OUT_EN
        scan_shift = 1'b0;
`endif
        step();
        step();
        chk("rst_sig",  sig3, 5'b00000);
        chk("rst_flags", {busy3, done3, pass3}, 3'b000);
        reset = 1'b0;

        // IDLE ignores enb
        enb = 1'b1; din = 5'b10101;
        step();
        chk("idle_hold", sig3, 5'b00000);
        enb = 1'b0;

        // test 1
        run_t1("t1", 1'b0);
        din = 5'b11111;
        step();
        chk("t1_hold_sig",  sig3, 5'b00100);
        chk("t1_hold_pass", {done3, pass3}, 2'b11);

`ifdef MISR_SCAN_OUT_EN
        // test 6: shift out 00100 LSB first
        begin
            logic [4:0] exp_bits;
            exp_bits = 5'b00100;
            scan_shift = 1'b1;
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("scan_bit%0d", i), scan_out3, exp_bits[i]);
                step();
                chk($sformatf("scan_pass%0d", i), {done3, pass3}, 2'b11);
            end
            scan_shift = 1'b0;
        end
`endif

        // test 3: stall two cycles between compactions 1 and 2
        start = 1'b1;
        step();
        chk("t3_restart", {busy3, done3, pass3}, 3'b100);
        start = 1'b0; enb = 1'b1; din = 5'b00001;
        step();
        chk("t3_c1", sig3, 5'b00001);
        enb = 1'b0; din = 5'b01010;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("t3_stall%0d_sig", i), sig3, 5'b00001);
            chk($sformatf("t3_stall%0d_busy", i), {busy3, done3}, 2'b10);
        end
        enb = 1'b1; din = 5'b00000;
        step();
        chk("t3_c2", sig3, 5'b00010);
        chk("t3_c2_notdone", done3, 0);
        step();
        chk("t3_c3", sig3, 5'b00100);
        chk("t3_done", {busy3, done3, pass3}, 3'b011);
        enb = 1'b0;

        // test 4: reset after compaction 2, then a clean rerun
        start = 1'b1;
        step();
        start = 1'b0; enb = 1'b1; din = 5'b00001;
        step();
        din = 5'b00000;
        step();
        chk("t4_pre_rst", sig3, 5'b00010);
        reset = 1'b1;
        step();
        reset = 1'b0; enb = 1'b0;
        chk("t4_rst_sig", sig3, 5'b00000);
        chk("t4_rst_flags", {busy3, done3, pass3}, 3'b000);
        step();
        chk("t4_no_done", done3, 0);
        run_t1("t4", 1'b0);

        // test 5: start held during COMPACT, then start in DONE
        start = 1'b1;
        step();
        chk("t5_clear", {busy3, done3, pass3}, 3'b100);
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        run_t1("t5", 1'b1);

        // test 2: two-cycle analyzer, din 11111 twice -> 11111, 00001; golden 00011 fails
        golden = 5'b00011;
        start  = 1'b1;
        step();
        start = 1'b0; enb = 1'b1; din = 5'b11111;
        step();
        chk("t2_c1", sig2, 5'b11111);
        chk("t2_c1_done", done2, 0);
        step();
        chk("t2_c2", sig2, 5'b00001);
        chk("t2_done", {busy2, done2, pass2}, 3'b010);
        enb = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/misr_signature_analyzer.md
Name: misr_signature_analyzer

Overview:
Response-side counterpart of the 5-bit LFSR pattern generator in the BIST path. It compacts the circuit-under-test response vector into a multiple-input signature register (MISR) for a fixed number of enabled cycles. It then compares the final signature with a golden value and reports pass/fail. It sits between the CUT outputs and the test controller and shares `enb` gating with the pattern LFSR.

Parameters:
WIDTH, 5, MISR and response vector width
TAPS, 5'b10100, feedback tap mask (bit i set = stage i in feedback XOR); default polynomial x^5+x^3+1
SEED, 5'b00000, signature value loaded on start
NUM_CYCLES, 31, number of enabled compaction cycles per run (one full LFSR period by default)
CNT_W, 5, counter width; must satisfy 2^CNT_W > NUM_CYCLES-1

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
enb  input  1  compaction enable; low stalls MISR and counter
start  input  1  one-cycle run request
din  input  WIDTH  CUT response vector
golden  input  WIDTH  expected final signature; sampled at completion
signature  output  WIDTH  current MISR contents
busy  output  1  high while compacting
done  output  1  high from run completion until next start
pass  output  1  valid when done; 1 = signature == golden

Behaviour:
- Reset (synchronous, `reset`=1 at a rising edge): state IDLE, signature=SEED, counter=0, busy=0, done=0, pass=0. Reset overrides all other inputs, including mid-run; a run in progress is abandoned with no done pulse.
- Feedback: fb = XOR-reduce(signature & TAPS).
- Next signature: next = {signature[WIDTH-2:0], fb} ^ din. All arithmetic is modulo WIDTH bits.
- FSM states: IDLE, COMPACT, DONE.
- IDLE: start=1 → signature<=SEED, counter<=0, go to COMPACT (busy=1 after the edge). enb is ignored in IDLE.
- COMPACT, enb=1: signature<=next, counter<=counter+1. If counter==NUM_CYCLES-1, go to DONE, done<=1, busy<=0, and pass<=(next==golden), compared in the same edge.
- COMPACT, enb=0: hold signature, counter and state.
- COMPACT: start is ignored.
- Latency, enb held high, start sampled at edge k: compactions occur at edges k+1 through k+NUM_CYCLES; done=1 and pass are valid after edge k+NUM_CYCLES.
- DONE: signature, pass and done hold. start=1 behaves as in IDLE (done<=0, pass<=0, reseed, go to COMPACT), so back-to-back runs have a one-cycle gap.
- din is don't-care outside enabled COMPACT cycles.
- golden is sampled only on the completing edge.

Optional Feature:
- MISR_SCAN_OUT_EN defined:
  - Adds ports `scan_shift` (input, 1) and `scan_out` (output, 1).
  - In DONE with scan_shift=1: signature shifts right one bit per cycle, zero-filled at MSB. `scan_out` = signature[0], combinational.
  - `pass` and `done` are unaffected by shifting.
  - scan_shift is ignored in IDLE and COMPACT.
- Undefined: these ports do not exist; signature holds in DONE.

Decomposition:
- Package `bist_pkg`:
  - BIST_WIDTH=5
  - DEFAULT_TAPS=5'b10100
  - state enum type (IDLE/COMPACT/DONE)
- Sub-module `misr_core`:
  - Register plus feedback/XOR.
  - Inputs: clk, reset, load, seed, shift_en, din.
  - Output: sig.
- Top holds the FSM, counter and compare.

Test Plan:
1. NUM_CYCLES=3, SEED=0. Pulse start, enb=1, din=00001,00000,00000 → signature 00001, 00010, 00100; done=1 after 3rd compaction. golden=00100 → pass=1.
2. NUM_CYCLES=2, din=11111 twice → signature 11111 then 00001. golden=00011 → done=1, pass=0.
3. Stall: as test 1 but enb=0 for 2 cycles between compactions 1 and 2 → signature holds 00001 and busy stays 1 during the stall; final 00100 and done are delayed by exactly 2 cycles.
4. Reset mid-run: assert reset after compaction 2 → next cycle IDLE, signature=00000, busy=0, done=0. A subsequent start rerun gives results identical to test 1.
5. start pulses during COMPACT are ignored (count is unaffected). start in DONE → done and pass clear next cycle and a new run completes normally.
6. With MISR_SCAN_OUT_EN, after test 1 (signature 00100): scan_shift=1 for 5 cycles → scan_out = 0,0,1,0,0; pass stays 1.
